read_operands_multi: RTL

READ_OPERANDS_MULTI -- requirements
Module: read_operands_multi

---
 rtl/read_operands_multi.sv | 198 +++++++++++++++++++
 1 files changed

// File: rtl/read_operands_multi.sv
// read_operands_multi
// ---------------------------------------------------------------------------
// Operand-read pipeline stage for a group of LANES decoded instructions.
// The stage holds one group. It drives register-file read addresses from the
// held source numbers and resolves each source from:
//   - register 0
//   - a forwarding (bypass) port, only when RO_BYPASS_EN is defined
//   - register-file data and its valid bit
// It then reports per-lane issue readiness, chained in lane order.
//
// Optional feature: define RO_BYPASS_EN to enable forwarding from the byp_*
// ports. When it is undefined, byp_* inputs are ignored.
//
// Handshake: a group is presented on ro_valid/ro_ready. When allowout=1 and
// flush=0, downstream accepts the whole group on that edge and the stage loads
// the next group from id_* (held valid[i] <= id_ready[i]). When allowout=0,
// the held group is kept unchanged. flush=1 drops the held group regardless.
//
// Ports
//   clk, reset (async, active-high), flush, allowout : control
//   id_ready, id_payload, id_have_exception, id_rf_src1, id_rf_src2,
//   id_src2_is_imm, id_imm                             : incoming group
//   r1_addr, r2_addr                                   : register-file read addresses
//   r1_valid, r2_valid, r1_data, r2_data               : register-file read data
//   byp_valid, byp_dest, byp_data                      : forwarding ports
//   ro_valid, ro_ready, ro_have_exception, ro_payload,
//   ro_src1, ro_src2, ro_st_data                       : outgoing group
//   ro_stall_cnt                                       : lane-0 stall cycles (saturating)
module read_operands_multi #(
    parameter int LANES     = 2,
    parameter int XLEN      = 32,
    parameter int PAYLOAD_W = 64,
    parameter int NBYP      = 2
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   flush,
    input  logic                   allowout,
    input  logic [LANES-1:0]       id_ready,
    input  logic [LANES*PAYLOAD_W-1:0] id_payload,
    input  logic [LANES-1:0]       id_have_exception,
    input  logic [LANES*5-1:0]     id_rf_src1,
    input  logic [LANES*5-1:0]     id_rf_src2,
    input  logic [LANES-1:0]       id_src2_is_imm,
    input  logic [LANES*XLEN-1:0]  id_imm,
    output logic [LANES*5-1:0]     r1_addr,
    output logic [LANES*5-1:0]     r2_addr,
    input  logic [LANES-1:0]       r1_valid,
    input  logic [LANES-1:0]       r2_valid,
    input  logic [LANES*XLEN-1:0]  r1_data,
    input  logic [LANES*XLEN-1:0]  r2_data,
    input  logic [NBYP-1:0]        byp_valid,
    input  logic [NBYP*5-1:0]      byp_dest,
    input  logic [NBYP*XLEN-1:0]   byp_data,
    output logic [LANES-1:0]       ro_valid,
    output logic [LANES-1:0]       ro_ready,
    output logic [LANES-1:0]       ro_have_exception,
    output logic [LANES*PAYLOAD_W-1:0] ro_payload,
    output logic [LANES*XLEN-1:0]  ro_src1,
    output logic [LANES*XLEN-1:0]  ro_src2,
    output logic [LANES*XLEN-1:0]  ro_st_data,
    output logic [31:0]            ro_stall_cnt
);

    // Held group state
    logic [LANES-1:0]           valid_q;
    logic [LANES*PAYLOAD_W-1:0] payload_q;
    logic [LANES-1:0]           exc_q;
    logic [LANES*5-1:0]         src1_q;
    logic [LANES*5-1:0]         src2_q;
    logic [LANES-1:0]           imm_sel_q;
    logic [LANES*XLEN-1:0]      imm_q;
    logic [31:0]                stall_q;

    // Resolved operands
    logic [LANES-1:0]           rdy1;
    logic [LANES-1:0]           rdy2;
    logic [LANES*XLEN-1:0]      val1;
    logic [LANES*XLEN-1:0]      val2;
    logic [LANES-1:0]           self_rdy;
    logic [LANES-1:0]           chain_rdy;

    // Valid bits are the only held state that reset touches.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_q <= '0;
        end else if (flush) begin
            valid_q <= '0;
        end else if (allowout) begin
            valid_q <= id_ready;
        end
    end

    always_ff @(posedge clk) begin
        if (allowout && !flush) begin
            payload_q <= id_payload;
            exc_q     <= id_have_exception;
            src1_q    <= id_rf_src1;
            src2_q    <= id_rf_src2;
            imm_sel_q <= id_src2_is_imm;
            imm_q     <= id_imm;
        end
    end

    // Returns {ready, data} for one source number.
    function automatic logic [XLEN:0] resolve(
        input logic [4:0]           src,
        input logic                 rf_v,
        input logic [XLEN-1:0]      rf_d
`ifdef RO_BYPASS_EN
        ,
        input logic [NBYP-1:0]      bv,
        input logic [NBYP*5-1:0]    bd,
        input logic [NBYP*XLEN-1:0] bdat
`endif
    );
        logic [XLEN:0] r;
        r = {rf_v, rf_d};
        if (src == 5'd0) begin
            r = {1'b1, {XLEN{1'b0}}};
        end
`ifdef RO_BYPASS_EN
        else begin
            // Descending scan so the lowest-index matching port is written last.
            for (int k = NBYP - 1; k >= 0; k--) begin
                if (bv[k] && (bd[k*5 +: 5] == src)) begin
                    r = {1'b1, bdat[k*XLEN +: XLEN]};
                end
            end
        end
`endif
        return r;
    endfunction

    always_comb begin
        rdy1 = '0;
        rdy2 = '0;
        val1 = '0;
        val2 = '0;
        for (int i = 0; i < LANES; i++) begin
`ifdef RO_BYPASS_EN
            {rdy1[i], val1[i*XLEN +: XLEN]} = resolve(src1_q[i*5 +: 5], r1_valid[i],
                r1_data[i*XLEN +: XLEN], byp_valid, byp_dest, byp_data);
            {rdy2[i], val2[i*XLEN +: XLEN]} = resolve(src2_q[i*5 +: 5], r2_valid[i],
                r2_data[i*XLEN +: XLEN], byp_valid, byp_dest, byp_data);
`else
            {rdy1[i], val1[i*XLEN +: XLEN]} = resolve(src1_q[i*5 +: 5], r1_valid[i],
                r1_data[i*XLEN +: XLEN]);
            {rdy2[i], val2[i*XLEN +: XLEN]} = resolve(src2_q[i*5 +: 5], r2_valid[i],
                r2_data[i*XLEN +: XLEN]);
`endif
        end
    end

`ifndef RO_BYPASS_EN
    logic unused_byp;
    assign unused_byp = ^{byp_valid, byp_dest, byp_data};
`endif

    // A lane with an exception issues without waiting for operands.
    // Readiness is chained so a lane never issues ahead of an older one.
    always_comb begin
        self_rdy  = valid_q & ((rdy1 & rdy2) | exc_q);
        chain_rdy = '0;
        chain_rdy[0] = self_rdy[0];
        for (int i = 1; i < LANES; i++) begin
            chain_rdy[i] = self_rdy[i] & chain_rdy[i-1];
        end
    end

    always_comb begin
        ro_src2 = '0;
        for (int i = 0; i < LANES; i++) begin
            ro_src2[i*XLEN +: XLEN] = imm_sel_q[i] ? imm_q[i*XLEN +: XLEN]
                                                   : val2[i*XLEN +: XLEN];
        end
    end

    // Stall counter saturates and is deliberately not cleared by flush.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_q <= '0;
        end else if (valid_q[0] && !chain_rdy[0] && !flush && (stall_q != 32'hFFFF_FFFF)) begin
            stall_q <= stall_q + 32'd1;
        end
    end

    assign r1_addr           = src1_q;
    assign r2_addr           = src2_q;
    assign ro_valid          = valid_q;
    assign ro_ready          = chain_rdy;
    assign ro_have_exception = exc_q;
    assign ro_payload        = payload_q;
    assign ro_src1           = val1;
    assign ro_st_data        = val2;
    assign ro_stall_cnt      = stall_q;

endmodule
